// File: rtl/core_run_ctrl_if.sv
// Run-control bus between the SMP controller / core pipeline and core_run_ctrl.
// master = controller + core side, slave = core_run_ctrl.
interface core_run_ctrl_if #(
  parameter int unsigned NUM_BKPT = 4
) ();
  localparam int unsigned IdxW = (NUM_BKPT > 1) ? $clog2(NUM_BKPT) : 1;

  logic            halt;
  logic            step;
  logic            cpu_alive;
  logic            cpu_halted;
  logic            breakpoint;
  logic            issue_valid;
  logic [31:0]     issue_pc;
  logic            issue_stall;
  logic            core_idle;
  logic            bkpt_write;
  logic [IdxW-1:0] bkpt_index;
  logic [29:0]     bkpt_addr;
  logic            bkpt_enable;

  modport master (
    output halt, step, issue_valid, issue_pc, core_idle,
           bkpt_write, bkpt_index, bkpt_addr, bkpt_enable,
    input  cpu_alive, cpu_halted, breakpoint, issue_stall
  );

  modport slave (
    input  halt, step, issue_valid, issue_pc, core_idle,
           bkpt_write, bkpt_index, bkpt_addr, bkpt_enable,
    output cpu_alive, cpu_halted, breakpoint, issue_stall
  );
endinterface

// File: rtl/core_run_ctrl.sv
// Per-core run control: halt/drain/step sequencing with issue gating and PC breakpoints.
// PC breakpoint comparators are present only when CORE_RUN_CTRL_BKPT_EN is defined.
module core_run_ctrl #(
  parameter int unsigned NUM_BKPT     = 4,
  parameter bit          START_HALTED = 1'b0
) (
  input logic            clk,
  input logic            rst,
  core_run_ctrl_if.slave bus
);
  localparam int unsigned IdxW = (NUM_BKPT > 1) ? $clog2(NUM_BKPT) : 1;

  typedef enum logic [1:0] {StRunning, StDraining, StHalted, StStepping} state_e;

  state_e r_state, w_state_nxt;
  logic   r_alive, r_halted, r_bkpt, r_skip, r_stepped;
  logic   w_halted_nxt, w_bkpt_nxt, w_skip_nxt, w_stepped_nxt;
  logic   w_stall, w_fire, w_hit;
  logic   w_unused_bkpt;

`ifdef CORE_RUN_CTRL_BKPT_EN
  logic [29:0]         r_slot_addr [NUM_BKPT];
  logic [NUM_BKPT-1:0] r_slot_en;
  logic [NUM_BKPT-1:0] w_slot_match;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BKPT; i++) r_slot_addr[i] <= '0;
      r_slot_en <= '0;
    end else if (bus.bkpt_write) begin
      // Out-of-range indices match no slot and are dropped.
      for (int i = 0; i < NUM_BKPT; i++) begin
        if (bus.bkpt_index == IdxW'(i)) begin
          r_slot_addr[i] <= bus.bkpt_addr;
          r_slot_en[i]   <= bus.bkpt_enable;
        end
      end
    end
  end

  always_comb begin
    w_slot_match = '0;
    for (int i = 0; i < NUM_BKPT; i++) begin
      w_slot_match[i] = r_slot_en[i] && (r_slot_addr[i] == bus.issue_pc[31:2]);
    end
  end

  assign w_hit          = bus.issue_valid && (|w_slot_match) && !r_skip;
  assign bus.breakpoint = r_bkpt;
  assign w_unused_bkpt  = ^bus.issue_pc[1:0];
`else
  assign w_hit          = 1'b0;
  assign bus.breakpoint = 1'b0;
  assign w_unused_bkpt  = ^{bus.issue_pc, bus.bkpt_write, bus.bkpt_index, bus.bkpt_addr,
                            bus.bkpt_enable, r_bkpt};
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_halted_nxt  = r_halted;
    w_bkpt_nxt    = r_bkpt;
    w_skip_nxt    = r_skip;
    w_stepped_nxt = r_stepped;
    w_stall       = 1'b1;
    unique case (r_state)
      StRunning: begin
        w_stall = w_hit;
        if (bus.halt || w_hit) begin
          w_state_nxt = StDraining;
          w_skip_nxt  = 1'b0;
          if (w_hit) w_bkpt_nxt = 1'b1;
        end
      end
      StDraining: begin
        if (bus.core_idle) begin
          w_state_nxt  = StHalted;
          w_halted_nxt = 1'b1;
        end
      end
      StHalted: begin
        if (bus.step) begin
          w_state_nxt   = StStepping;
          w_halted_nxt  = 1'b0;
          w_bkpt_nxt    = 1'b0;
          w_stepped_nxt = 1'b0;
        end else if (!bus.halt) begin
          // Let the breakpointed instruction through once on resume.
          w_state_nxt  = StRunning;
          w_halted_nxt = 1'b0;
          w_bkpt_nxt   = 1'b0;
          w_skip_nxt   = r_bkpt;
        end
      end
      StStepping: begin
        w_stall = r_stepped;
        if (r_stepped && bus.core_idle) begin
          w_state_nxt  = StHalted;
          w_halted_nxt = 1'b1;
        end
      end
      default: w_state_nxt = StHalted;
    endcase

    w_fire = bus.issue_valid && !w_stall;
    if (w_fire) begin
      w_skip_nxt    = 1'b0;
      w_stepped_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= START_HALTED ? StHalted : StRunning;
      r_alive   <= 1'b0;
      r_halted  <= START_HALTED;
      r_bkpt    <= 1'b0;
      r_skip    <= 1'b0;
      r_stepped <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_alive   <= r_alive | w_fire;
      r_halted  <= w_halted_nxt;
      r_bkpt    <= w_bkpt_nxt;
      r_skip    <= w_skip_nxt;
      r_stepped <= w_stepped_nxt;
    end
  end

  assign bus.issue_stall = w_stall;
  assign bus.cpu_alive   = r_alive;
  assign bus.cpu_halted  = r_halted;
endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl (NUM_BKPT=4, START_HALTED=0).
// Breakpoint scenarios follow CORE_RUN_CTRL_BKPT_EN; otherwise breakpoints must stay inert.
module tb_core_run_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  int   issue_cnt = 0;
  int   base;

  core_run_ctrl_if #(.NUM_BKPT(4)) bus ();

  core_run_ctrl #(.NUM_BKPT(4), .START_HALTED(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Inputs change at posedge+2, so negedge sees a stable handshake.
  always @(negedge clk) begin
    if (!rst && bus.issue_valid && !bus.issue_stall) issue_cnt <= issue_cnt + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    bus.halt = 0; bus.step = 0; bus.issue_valid = 1; bus.issue_pc = 32'h0; bus.core_idle = 1;
    bus.bkpt_write = 0; bus.bkpt_index = '0; bus.bkpt_addr = '0; bus.bkpt_enable = 0;
    rst = 1;
    #3;
    n_chk++; if (bus.cpu_alive !== 1'b0) begin n_err++; $display("FAIL rst_alive: got %b want 0", bus.cpu_alive); end
    n_chk++; if (bus.cpu_halted !== 1'b0) begin n_err++; $display("FAIL rst_halted: got %b want 0", bus.cpu_halted); end
    n_chk++; if (bus.breakpoint !== 1'b0) begin n_err++; $display("FAIL rst_bkpt: got %b want 0", bus.breakpoint); end
    tick();
    rst = 0;
    #1;
    n_chk++; if (bus.issue_stall !== 1'b0) begin n_err++; $display("FAIL run_stall: got %b want 0", bus.issue_stall); end
    n_chk++; if (bus.cpu_alive !== 1'b0) begin n_err++; $display("FAIL alive_early: got %b want 0", bus.cpu_alive); end
    tick();
    n_chk++; if (bus.cpu_alive !== 1'b1) begin n_err++; $display("FAIL alive_set: got %b want 1", bus.cpu_alive); end
    n_chk++; if (issue_cnt !== 1) begin n_err++; $display("FAIL first_issue: got %0d want 1", issue_cnt); end
    n_chk++; if (bus.cpu_halted !== 1'b0) begin n_err++; $display("FAIL run_halted: got %b want 0", bus.cpu_halted); end
  endtask

  task automatic test_drain();
    bus.core_idle = 0;
    bus.halt = 1;
    tick();
    #1;
    n_chk++; if (bus.issue_stall !== 1'b1) begin n_err++; $display("FAIL drain_stall: got %b want 1", bus.issue_stall); end
    base = issue_cnt;
    for (int i = 0; i < 5; i++) begin
      n_chk++; if (bus.cpu_halted !== 1'b0) begin n_err++; $display("FAIL drain_early_halt: got %b want 0", bus.cpu_halted); end
      tick();
    end
    bus.core_idle = 1;
    n_chk++; if (bus.cpu_halted !== 1'b0) begin n_err++; $display("FAIL drain_idle_cycle: got %b want 0", bus.cpu_halted); end
    tick();
    n_chk++; if (bus.cpu_halted !== 1'b1) begin n_err++; $display("FAIL drain_halted: got %b want 1", bus.cpu_halted); end
    n_chk++; if (issue_cnt !== base) begin n_err++; $display("FAIL drain_no_issue: got %0d want %0d", issue_cnt, base); end
  endtask

  task automatic test_step();
    base = issue_cnt;
    bus.core_idle = 0;
    bus.step = 1;
    #1;
    n_chk++; if (bus.issue_stall !== 1'b1) begin n_err++; $display("FAIL halted_stall: got %b want 1", bus.issue_stall); end
    tick();
    bus.step = 0;
    #1;
    n_chk++; if (bus.issue_stall !== 1'b0) begin n_err++; $display("FAIL step_open: got %b want 0", bus.issue_stall); end
    n_chk++; if (bus.cpu_halted !== 1'b0) begin n_err++; $display("FAIL step_halted_drop: got %b want 0", bus.cpu_halted); end
    tick();
    #1;
    n_chk++; if (bus.issue_stall !== 1'b1) begin n_err++; $display("FAIL step_closed: got %b want 1", bus.issue_stall); end
    tick();
    n_chk++; if (bus.cpu_halted !== 1'b0) begin n_err++; $display("FAIL step_wait_idle: got %b want 0", bus.cpu_halted); end
    bus.core_idle = 1;
    tick();
    n_chk++; if (bus.cpu_halted !== 1'b1) begin n_err++; $display("FAIL step_rehalt: got %b want 1", bus.cpu_halted); end
    n_chk++; if (issue_cnt !== base + 1) begin n_err++; $display("FAIL step_one_issue: got %0d want %0d", issue_cnt, base + 1); end
    bus.step = 1;
    tick();
    bus.step = 0;
    tick();
    tick();
    n_chk++; if (bus.cpu_halted !== 1'b1) begin n_err++; $display("FAIL step2_rehalt: got %b want 1", bus.cpu_halted); end
    n_chk++; if (issue_cnt !== base + 2) begin n_err++; $display("FAIL step2_issue: got %0d want %0d", issue_cnt, base + 2); end
  endtask

  task automatic test_step_ignored();
    bus.halt = 0;
    tick();
    n_chk++; if (bus.cpu_halted !== 1'b0) begin n_err++; $display("FAIL resume_halted: got %b want 0", bus.cpu_halted); end
    bus.step = 1;
    tick();
    bus.step = 0;
    tick();
    tick();
    #1;
    n_chk++; if (bus.cpu_halted !== 1'b0) begin n_err++; $display("FAIL run_step_halted: got %b want 0", bus.cpu_halted); end
    n_chk++; if (bus.issue_stall !== 1'b0) begin n_err++; $display("FAIL run_step_stall: got %b want 0", bus.issue_stall); end
    bus.halt = 1;
    tick();
    tick();
    n_chk++; if (bus.cpu_halted !== 1'b1) begin n_err++; $display("FAIL min_latency: got %b want 1", bus.cpu_halted); end
    base = issue_cnt;
    bus.step = 1;
    bus.halt = 0;
    tick();
    bus.step = 0;
    bus.halt = 1;
    #1;
    n_chk++; if (bus.cpu_halted !== 1'b0) begin n_err++; $display("FAIL prio_step_entry: got %b want 0", bus.cpu_halted); end
    tick();
    tick();
    n_chk++; if (bus.cpu_halted !== 1'b1) begin n_err++; $display("FAIL prio_rehalt: got %b want 1", bus.cpu_halted); end
    n_chk++; if (issue_cnt !== base + 1) begin n_err++; $display("FAIL prio_issue: got %0d want %0d", issue_cnt, base + 1); end
    tick();
    n_chk++; if (bus.cpu_halted !== 1'b1) begin n_err++; $display("FAIL prio_stay: got %b want 1", bus.cpu_halted); end
  endtask

`ifdef CORE_RUN_CTRL_BKPT_EN
  task automatic test_breakpoint();
    bus.issue_pc = 32'h100;
    bus.halt = 0;
    tick();
    bus.bkpt_write = 1; bus.bkpt_index = 2'd2; bus.bkpt_addr = 30'h40; bus.bkpt_enable = 1;
    #1;
    n_chk++; if (bus.issue_stall !== 1'b0) begin n_err++; $display("FAIL bkpt_old_slot: got %b want 0", bus.issue_stall); end
    tick();
    bus.bkpt_write = 0;
    #1;
    n_chk++; if (bus.issue_stall !== 1'b1) begin n_err++; $display("FAIL bkpt_hit_stall: got %b want 1", bus.issue_stall); end
    base = issue_cnt;
    bus.halt = 1;
    tick();
    n_chk++; if (bus.breakpoint !== 1'b1) begin n_err++; $display("FAIL bkpt_flag: got %b want 1", bus.breakpoint); end
    tick();
    n_chk++; if (bus.cpu_halted !== 1'b1) begin n_err++; $display("FAIL bkpt_halted: got %b want 1", bus.cpu_halted); end
    n_chk++; if (issue_cnt !== base) begin n_err++; $display("FAIL bkpt_not_issued: got %0d want %0d", issue_cnt, base); end
    bus.halt = 0;
    tick();
    #1;
    n_chk++; if (bus.breakpoint !== 1'b0) begin n_err++; $display("FAIL bkpt_clear: got %b want 0", bus.breakpoint); end
    n_chk++; if (bus.issue_stall !== 1'b0) begin n_err++; $display("FAIL skip_stall: got %b want 0", bus.issue_stall); end
    tick();
    bus.issue_pc = 32'h104;
    n_chk++; if (issue_cnt !== base + 1) begin n_err++; $display("FAIL skip_issue: got %0d want %0d", issue_cnt, base + 1); end
    tick();
    bus.issue_pc = 32'h100;
    #1;
    n_chk++; if (bus.issue_stall !== 1'b1) begin n_err++; $display("FAIL refetch_stall: got %b want 1", bus.issue_stall); end
    bus.halt = 1;
    tick();
    n_chk++; if (bus.breakpoint !== 1'b1) begin n_err++; $display("FAIL refetch_flag: got %b want 1", bus.breakpoint); end
    tick();
    n_chk++; if (bus.cpu_halted !== 1'b1) begin n_err++; $display("FAIL refetch_halted: got %b want 1", bus.cpu_halted); end
  endtask
`else
  task automatic test_breakpoint();
    bus.issue_pc = 32'h100;
    bus.halt = 0;
    tick();
    bus.bkpt_write = 1; bus.bkpt_index = 2'd2; bus.bkpt_addr = 30'h40; bus.bkpt_enable = 1;
    tick();
    bus.bkpt_write = 0;
    #1;
    n_chk++; if (bus.issue_stall !== 1'b0) begin n_err++; $display("FAIL nobkpt_stall: got %b want 0", bus.issue_stall); end
    tick();
    n_chk++; if (bus.breakpoint !== 1'b0) begin n_err++; $display("FAIL nobkpt_flag: got %b want 0", bus.breakpoint); end
    n_chk++; if (bus.cpu_halted !== 1'b0) begin n_err++; $display("FAIL nobkpt_halted: got %b want 0", bus.cpu_halted); end
    bus.halt = 1;
    tick();
    tick();
    n_chk++; if (bus.cpu_halted !== 1'b1) begin n_err++; $display("FAIL nobkpt_rehalt: got %b want 1", bus.cpu_halted); end
  endtask
`endif

  task automatic test_rst_mid_step();
    bus.issue_valid = 0;
    bus.step = 1;
    tick();
    bus.step = 0;
    #1;
    n_chk++; if (bus.cpu_halted !== 1'b0) begin n_err++; $display("FAIL rs_stepping: got %b want 0", bus.cpu_halted); end
    rst = 1;
    #1;
    n_chk++; if (bus.cpu_alive !== 1'b0) begin n_err++; $display("FAIL rs_alive: got %b want 0", bus.cpu_alive); end
    n_chk++; if (bus.cpu_halted !== 1'b0) begin n_err++; $display("FAIL rs_halted: got %b want 0", bus.cpu_halted); end
    n_chk++; if (bus.breakpoint !== 1'b0) begin n_err++; $display("FAIL rs_bkpt: got %b want 0", bus.breakpoint); end
    bus.halt = 0;
    bus.issue_valid = 1;
    bus.issue_pc = 32'h100;
    tick();
    rst = 0;
    #1;
    n_chk++; if (bus.issue_stall !== 1'b0) begin n_err++; $display("FAIL rs_slots_clear: got %b want 0", bus.issue_stall); end
    tick();
    n_chk++; if (bus.cpu_alive !== 1'b1) begin n_err++; $display("FAIL rs_alive_again: got %b want 1", bus.cpu_alive); end
  endtask

  initial begin
    test_reset();
    test_drain();
    test_step();
    test_step_ignored();
    test_breakpoint();
    test_rst_mid_step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/core_run_ctrl.md
Name: core_run_ctrl

Overview:
- Per-core run-control stage directly downstream of the SMP controller.
- Consumes that core's halt/step request lines and gates instruction issue in the core.
- Drains the pipeline before reporting halted, and implements PC breakpoint comparators.
- Produces the cpu_alive / cpu_halted / breakpoint status lines that the SMP controller reads back; one instance per core.

Parameters:
NUM_BKPT, 4, number of PC breakpoint comparators (1..16)
START_HALTED, 0, 1 = core comes out of reset held in HALTED instead of RUNNING

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
halt  in  1  level from SMP controller: request core stopped
step  in  1  one-cycle pulse from SMP controller: execute exactly one instruction while halted
cpu_alive  out  1  sticky: core has issued at least one instruction since reset
cpu_halted  out  1  core stopped with pipeline empty
breakpoint  out  1  current halt was caused by a breakpoint match
issue_valid  in  1  core has an instruction ready to issue
issue_pc  in  32  PC of that instruction
issue_stall  out  1  combinational: blocks issue; instruction issues when issue_valid && !issue_stall
core_idle  in  1  no instructions in flight in the core pipeline
bkpt_write  in  1  write strobe for a breakpoint slot
bkpt_index  in  $clog2(NUM_BKPT) (min 1)  slot selected
bkpt_addr  in  30  word address to match, compared against issue_pc[31:2]
bkpt_enable  in  1  slot enable written with bkpt_addr

Behaviour:
- Reset (async):
  - state = HALTED if START_HALTED, else RUNNING.
  - cpu_alive=0, breakpoint=0, skip=0; all slots disabled, addresses 0.
  - cpu_halted = START_HALTED ? 1 : 0.
- States: RUNNING, DRAINING, HALTED, STEPPING. All status outputs are registered.
- Match:
  - hit = issue_valid && any enabled slot with addr == issue_pc[31:2] && !skip.
  - Multiple slots matching count as a single hit.
- RUNNING:
  - issue_stall = hit.
  - On halt=1 or hit: go to DRAINING. On hit, set breakpoint=1 the next cycle.
  - The matching instruction is NOT issued.
- DRAINING:
  - issue_stall=1.
  - When core_idle=1: go to HALTED and set cpu_halted=1 the next cycle.
  - Minimum latency from halt rise to cpu_halted: 2 cycles.
- HALTED:
  - issue_stall=1; cpu_halted=1.
  - step=1: go to STEPPING. step has priority over halt=0 in the same cycle.
  - Otherwise halt=0: go to RUNNING with cpu_halted=0 and breakpoint=0 the next cycle.
    - If breakpoint was 1, set skip=1 so the breakpointed instruction can issue once.
- STEPPING:
  - cpu_halted=0. issue_stall=0 until exactly one issue handshake, then 1.
  - Breakpoint matches are ignored for the stepped instruction.
  - After the issue, when core_idle=1: return to HALTED (cpu_halted=1). breakpoint is cleared on step entry.
- skip: cleared on the first issue handshake after it is set, or on entry to DRAINING.
- step pulses outside HALTED are ignored (no queueing).
- cpu_alive: set on the first issue handshake; stays 1 until rst.
- Breakpoint writes:
  - Take effect the cycle after bkpt_write. Allowed in any state.
  - A write in the same cycle as a would-be hit uses the old slot contents.
  - bkpt_index >= NUM_BKPT is ignored.
- halt falling during DRAINING: drain still completes to HALTED, then HALTED→RUNNING the following cycle (one-cycle cpu_halted pulse is required so the controller sees the stop).
- rst asserted mid-step or mid-drain: immediate return to reset state. Issued instructions are the core's concern.

Optional Feature:
- Macro: CORE_RUN_CTRL_BKPT_EN.
- Defined: comparators, skip logic and the breakpoint status as above.
- Undefined:
  - No comparator storage; bkpt_* inputs are ignored.
  - hit is constant 0; breakpoint is tied 0.
  - halt/step behaviour is unchanged.

Test Plan:
- Reset with START_HALTED=0, issue_valid=1 → issue_stall=0 on cycle 1, cpu_alive=1 after the first issue, cpu_halted=0, breakpoint=0.
- halt=1 with core_idle held 0 for 5 cycles, then 1 → issue_stall=1 from the cycle after halt, no issues, cpu_halted=1 exactly 1 cycle after core_idle rises.
- Halted, pulse step with issue_valid=1 → exactly one issue handshake, cpu_halted drops then returns to 1 after core_idle; second step → one more issue.
- Slot 2 = 0x100>>2 enabled, running, issue_pc=0x100 → not issued, breakpoint=1 and cpu_halted=1; halt=0 → 0x100 issues once (skip), re-fetch of 0x100 later halts again.
- step pulse while RUNNING and step together with halt=0 while HALTED → first ignored; second performs a single step and stays halted.
- rst asserted during STEPPING before issue → outputs return to reset values asynchronously, bkpt slots cleared.
